// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch (IF) and load/store (DM) ports.
// Each access: fixed wait states with mem_ce asserted, then a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_DM_RUN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_req
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] RUN_MAX   = 4'(MAX_DM_RUN);

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [3:0]          run_q, run_d;
  logic                owner_dm_q, owner_dm_d;
  logic                mem_ce_q, mem_ce_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_q      <= 4'd0;
      run_q       <= 4'd0;
      owner_dm_q  <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 4'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      run_q       <= run_d;
      owner_dm_q  <= owner_dm_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  // Arbitration, wait-state sequencing and read-data capture.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    run_d       = run_q;
    owner_dm_d  = owner_dm_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        wait_d = 4'd0;
        // DM has priority until it has won RUN_MAX times in a row over a waiting fetch.
        if (dm_req && (!if_req || (run_q < RUN_MAX))) begin
          owner_dm_d  = 1'b1;
          run_d       = if_req ? (run_q + 4'd1) : 4'd0;
          mem_ce_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_sel_d   = dm_sel;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = ACCESS;
        end else if (if_req) begin
          owner_dm_d  = 1'b0;
          run_d       = 4'd0;
          mem_ce_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_sel_d   = 4'hF;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          wait_d   = 4'd0;
          mem_ce_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = RESP;
          if (owner_dm_q) begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_ce_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Held low during reset so every output reads 0 while rst is asserted.
  assign stall_req = rst & ((if_req & ~if_ack_q) | (dm_req & ~dm_ack_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=1, one with 3.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  // instance A: WAIT_CYCLES=1, MAX_DM_RUN=4
  logic        rst1 = 1'b0;
  logic        if_req1 = 1'b0, dm_req1 = 1'b0, dm_we1 = 1'b0;
  logic [31:0] if_addr1 = 32'd0, dm_addr1 = 32'd0, dm_wdata1 = 32'd0, mem_rdata1 = 32'd0;
  logic [3:0]  dm_sel1 = 4'd0;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_ack1, dm_ack1, mem_ce1, mem_we1, stall1;
  logic [3:0]  mem_sel1;

  // instance B: WAIT_CYCLES=3
  logic        rst3 = 1'b0;
  logic        if_req3 = 1'b0, dm_req3 = 1'b0;
  logic [31:0] if_addr3 = 32'd0, dm_addr3 = 32'd0, mem_rdata3 = 32'd0;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3;
  logic        if_ack3, dm_ack3, mem_ce3, mem_we3, stall3;
  logic [3:0]  mem_sel3;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .MAX_DM_RUN(4)) u_dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_sel(dm_sel1), .dm_addr(dm_addr1),
    .dm_wdata(dm_wdata1), .dm_rdata(dm_rdata1), .dm_ack(dm_ack1),
    .mem_ce(mem_ce1), .mem_we(mem_we1), .mem_sel(mem_sel1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall_req(stall1)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3), .MAX_DM_RUN(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ack(if_ack3),
    .dm_req(dm_req3), .dm_we(1'b0), .dm_sel(4'hF), .dm_addr(dm_addr3),
    .dm_wdata(32'd0), .dm_rdata(dm_rdata3), .dm_ack(dm_ack3),
    .mem_ce(mem_ce3), .mem_we(mem_we3), .mem_sel(mem_sel3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .stall_req(stall3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] seq;
    int         nacks;
    int         last_cyc;

    // Reset held with a fetch pending.
    rst3       = 1'b0;
    if_req1    = 1'b1;
    if_addr1   = 32'h0000_0010;
    mem_rdata1 = 32'h2401_0005;
    repeat (2) @(negedge clk);
    check("rst_mem_ce", {31'd0, mem_ce1}, 32'd0);
    check("rst_if_ack", {31'd0, if_ack1}, 32'd0);
    check("rst_stall", {31'd0, stall1}, 32'd0);
    check("rst_mem_addr", mem_addr1, 32'd0);
    check("rst_mem_sel", {28'd0, mem_sel1}, 32'd0);
    check("rst_if_rdata", if_rdata1, 32'd0);
    rst1 = 1'b1;
    rst3 = 1'b1;
    #1;
    check("f_c0_stall", {31'd0, stall1}, 32'd1);
    check("f_c0_ce", {31'd0, mem_ce1}, 32'd0);
    @(negedge clk);
    check("f_c1_ce", {31'd0, mem_ce1}, 32'd1);
    check("f_c1_addr", mem_addr1, 32'h0000_0010);
    check("f_c1_sel", {28'd0, mem_sel1}, 32'h0000_000F);
    check("f_c1_we", {31'd0, mem_we1}, 32'd0);
    check("f_c1_stall", {31'd0, stall1}, 32'd1);
    check("f_c1_ack", {31'd0, if_ack1}, 32'd0);
    @(negedge clk);
    check("f_c2_ack", {31'd0, if_ack1}, 32'd1);
    check("f_c2_rdata", if_rdata1, 32'h2401_0005);
    check("f_c2_ce", {31'd0, mem_ce1}, 32'd0);
    check("f_c2_stall", {31'd0, stall1}, 32'd0);
    if_req1 = 1'b0;
    @(negedge clk);
    check("f_c3_ack", {31'd0, if_ack1}, 32'd0);
    check("f_c3_rdata_hold", if_rdata1, 32'h2401_0005);

    // Data write: nothing captured into dm_rdata.
    dm_req1    = 1'b1;
    dm_we1     = 1'b1;
    dm_sel1    = 4'b0011;
    dm_addr1   = 32'h0000_0100;
    dm_wdata1  = 32'hDEAD_BEEF;
    mem_rdata1 = 32'h5555_5555;
    #1;
    check("w_c0_stall", {31'd0, stall1}, 32'd1);
    @(negedge clk);
    check("w_c1_ce", {31'd0, mem_ce1}, 32'd1);
    check("w_c1_we", {31'd0, mem_we1}, 32'd1);
    check("w_c1_sel", {28'd0, mem_sel1}, 32'h0000_0003);
    check("w_c1_addr", mem_addr1, 32'h0000_0100);
    check("w_c1_wdata", mem_wdata1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("w_c2_ack", {31'd0, dm_ack1}, 32'd1);
    check("w_c2_we", {31'd0, mem_we1}, 32'd0);
    check("w_c2_rdata", dm_rdata1, 32'd0);
    dm_req1 = 1'b0;
    dm_we1  = 1'b0;
    @(negedge clk);

    // Contention: DM read first, then the fetch.
    dm_req1    = 1'b1;
    dm_sel1    = 4'hF;
    dm_addr1   = 32'h0000_0200;
    if_req1    = 1'b1;
    if_addr1   = 32'h0000_0020;
    mem_rdata1 = 32'hAAAA_0001;
    @(negedge clk);
    check("c_c1_addr", mem_addr1, 32'h0000_0200);
    check("c_c1_we", {31'd0, mem_we1}, 32'd0);
    @(negedge clk);
    check("c_c2_dm_ack", {31'd0, dm_ack1}, 32'd1);
    check("c_c2_dm_rdata", dm_rdata1, 32'hAAAA_0001);
    check("c_c2_if_ack", {31'd0, if_ack1}, 32'd0);
    check("c_c2_stall", {31'd0, stall1}, 32'd1);
    dm_req1    = 1'b0;
    mem_rdata1 = 32'hBBBB_0002;
    @(negedge clk);
    check("c_c3_ce", {31'd0, mem_ce1}, 32'd0);
    @(negedge clk);
    check("c_c4_ce", {31'd0, mem_ce1}, 32'd1);
    check("c_c4_addr", mem_addr1, 32'h0000_0020);
    @(negedge clk);
    check("c_c5_if_ack", {31'd0, if_ack1}, 32'd1);
    check("c_c5_if_rdata", if_rdata1, 32'hBBBB_0002);
    check("c_c5_dm_rdata", dm_rdata1, 32'hAAAA_0001);
    if_req1 = 1'b0;
    @(negedge clk);

    // Starvation: DM held continuously with a fetch pending.
    dm_req1  = 1'b1;
    if_req1  = 1'b1;
    seq      = 6'd0;
    nacks    = 0;
    last_cyc = 0;
    for (int c = 0; c < 60 && nacks < 6; c++) begin
      @(negedge clk);
      if (dm_ack1 && if_ack1) begin
        check("s_dual_ack", 32'd1, 32'd0);
      end
      if (dm_ack1) begin
        seq = {seq[4:0], 1'b0};
        nacks++;
        last_cyc = c + 1;
      end else if (if_ack1) begin
        seq = {seq[4:0], 1'b1};
        nacks++;
        last_cyc = c + 1;
        if_req1 = 1'b0;
      end
    end
    check("s_nacks", 32'(nacks), 32'd6);
    check("s_order", {26'd0, seq}, 32'h0000_0002);
    check("s_last_cycle", 32'(last_cyc), 32'd17);
    dm_req1 = 1'b0;
    if_req1 = 1'b0;

    // WAIT_CYCLES=3: reset during the second ACCESS cycle.
    dm_req3    = 1'b1;
    dm_addr3   = 32'h0000_0300;
    mem_rdata3 = 32'h0BAD_0BAD;
    @(negedge clk);
    check("r_c1_ce", {31'd0, mem_ce3}, 32'd1);
    @(negedge clk);
    check("r_c2_ce", {31'd0, mem_ce3}, 32'd1);
    #2 rst3 = 1'b0;
    #1;
    check("r_async_ce", {31'd0, mem_ce3}, 32'd0);
    check("r_async_ack", {31'd0, dm_ack3}, 32'd0);
    dm_req3    = 1'b0;
    if_req3    = 1'b1;
    if_addr3   = 32'h0000_0040;
    mem_rdata3 = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("r_hold_ack", {31'd0, dm_ack3}, 32'd0);
    check("r_hold_rdata", dm_rdata3, 32'd0);
    rst3 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("r_post_ce", {31'd0, mem_ce3}, (c <= 3) ? 32'd1 : 32'd0);
      check("r_post_ack", {31'd0, if_ack3}, (c == 4) ? 32'd1 : 32'd0);
      check("r_post_dm_ack", {31'd0, dm_ack3}, 32'd0);
    end
    check("r_post_rdata", if_rdata3, 32'h1234_5678);
    if_req3 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-port unified instruction/data memory between the CPU fetch port (IF) and the load/store port (DM) inside the spoc.
- Sequences each memory access with a fixed wait-state count and returns read data with a one-cycle ack pulse.
- Drives a stall request to the pipeline control while any port is waiting.
- Data port has priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 1, cycles mem_ce is held before mem_rdata is sampled; legal range 1..15
- MAX_DM_RUN, 4, max consecutive DM grants while if_req is pending; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data, valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_sel  in  4  byte enables
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  load data, valid when dm_ack=1
- dm_ack  out  1  one-cycle completion pulse
- mem_ce  out  1  memory chip enable
- mem_we  out  1  memory write enable
- mem_sel  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stall_req  out  1  pipeline stall request

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, run counter=0, all outputs 0. Reset mid-access abandons the access: no ack is issued and mem_ce drops immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: requests are sampled only in this state.
  - dm_req=1 and (if_req=0 or run<MAX_DM_RUN): grant DM, run=run+1 when if_req=1, else run=0.
  - Otherwise, if if_req=1: grant IF, run=0.
  - On a grant, latch the owner, address, we, sel and wdata into output registers and go to ACCESS. For an IF grant: mem_we=0, mem_sel=4'hF.
  - No request: stay in IDLE.
- ACCESS: mem_ce=1 and the latched fields are driven for exactly WAIT_CYCLES cycles, counted by the wait counter.
  - At the end of the last ACCESS cycle, mem_rdata is captured into the owner's rdata register. Writes capture nothing; dm_rdata holds its previous value.
  - Go to RESP; mem_ce and mem_we return to 0.
- RESP: the owner's ack=1 for exactly one cycle, then go to IDLE. Requests present during RESP are ignored.
- Latency: req high in cycle 0 gives mem_ce in cycles 1..WAIT_CYCLES and ack in cycle WAIT_CYCLES+1. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Requester contract: req and its address/data are stable until ack. A req drop mid-access does not abort the access; the ack is still pulsed.
- Simultaneous requests in IDLE: DM wins unless run==MAX_DM_RUN, in which case IF wins and run clears.
- stall_req = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
- if_rdata and dm_rdata hold their last captured value between acks.

Test Plan:
- Reset: hold rst=0 with if_req=1 -> all outputs 0, no mem_ce. Release rst -> mem_ce=1 one cycle later.
- Single fetch, WAIT_CYCLES=1: if_addr=0x00000010, mem_rdata=0x24010005 -> mem_ce in cycle 1, if_ack=1 and if_rdata=0x24010005 in cycle 2, stall_req=1 in cycles 0..1.
- Data write: dm_we=1, dm_sel=4'b0011, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_we=1, mem_sel=0011 during ACCESS, dm_ack pulse, dm_rdata unchanged.
- Contention: if_req and dm_req raised together -> DM served first; IF is served in the IDLE after DM's RESP.
- Starvation, MAX_DM_RUN=4: dm_req held continuously with if_req pending -> exactly 4 DM acks, then 1 IF ack, then DM resumes.
- WAIT_CYCLES=3 plus reset in the second ACCESS cycle -> mem_ce falls asynchronously, no ack. The next request after reset completes normally with ack in cycle 4.
